// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the writeback/long-latency producers and the
// register-file write arbiter.
interface regfile_wr_arbiter_if;
    logic        WbValid__i;
    logic [4:0]  WbAddr__i;
    logic [31:0] WbData__i;
    // LL handshake: a result transfers on a cycle where LlValid__i and LlReady__o are both 1.
    logic        LlValid__i;
    logic [4:0]  LlAddr__i;
    logic [31:0] LlData__i;
    logic        LlReady__o;
    logic        RegWrite__o;
    logic [4:0]  AddrRd__o;
    logic [31:0] DataRd__o;
    logic        StallReq__o;
    logic [31:0] PendMask__o;
    logic        ProtoErr__o;

    modport master (
        output WbValid__i, WbAddr__i, WbData__i, LlValid__i, LlAddr__i, LlData__i,
        input  LlReady__o, RegWrite__o, AddrRd__o, DataRd__o, StallReq__o, PendMask__o,
               ProtoErr__o
    );

    modport slave (
        input  WbValid__i, WbAddr__i, WbData__i, LlValid__i, LlAddr__i, LlData__i,
        output LlReady__o, RegWrite__o, AddrRd__o, DataRd__o, StallReq__o, PendMask__o,
               ProtoErr__o
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between pipeline writeback and a queued
// long-latency result stream; queued results drain into idle WB slots.
module regfile_wr_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input logic                 clock__i,
    input logic                 rst_n__i,
    regfile_wr_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_DEPTH-1:0] valid_q, valid_d;
    logic [4:0]            addr_q [FIFO_DEPTH];
    logic [4:0]            addr_d [FIFO_DEPTH];
    logic [31:0]           data_q [FIFO_DEPTH];
    logic [31:0]           data_d [FIFO_DEPTH];
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  stall_q, stall_d;
    logic                  proto_err_q, proto_err_d;

    logic        empty, full, push, pop, head_win, wb_win;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic [31:0] pend;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        // Head beats WB only when stalling; otherwise it takes idle WB slots.
        head_win = !empty && (stall_q || !bus.WbValid__i);
        wb_win   = bus.WbValid__i && !head_win;
        push     = bus.LlValid__i && !full;
        pop      = head_win;
        sel_addr = head_win ? addr_q[rd_ptr_q] : bus.WbAddr__i;
        sel_data = head_win ? data_q[rd_ptr_q] : bus.WbData__i;
        pend     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[i]) pend[addr_q[i]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    always_comb begin
        bus.LlReady__o  = !full;
        bus.AddrRd__o   = sel_addr;
        bus.DataRd__o   = sel_data;
        bus.RegWrite__o = rst_n__i && (head_win || wb_win) && (sel_addr != 5'd0);
        bus.StallReq__o = stall_q;
        bus.PendMask__o = pend;
        bus.ProtoErr__o = proto_err_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wait_d      = wait_q;
        stall_d     = stall_q;
        proto_err_d = proto_err_q;

        if (push) begin
            addr_d[wr_ptr_q]  = bus.LlAddr__i;
            data_d[wr_ptr_q]  = bus.LlData__i;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop || empty)
            wait_d = '0;
        else if (wait_q != WAIT_W'(MAX_WAIT))
            wait_d = wait_q + WAIT_W'(1);

        stall_d = ((wait_q == WAIT_W'(MAX_WAIT - 1)) && !empty && !pop) || (stall_q && !pop);
        // A WB write during a stall with a queued head is dropped and flagged.
        proto_err_d = proto_err_q || (bus.WbValid__i && stall_q && !empty);
    end

    always_ff @(posedge clock__i or negedge rst_n__i) begin
        if (!rst_n__i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            wait_q      <= '0;
            stall_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            wait_q      <= wait_d;
            stall_q     <= stall_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clock__i) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: WB pass-through, LL drain, starvation
// stall, FIFO full behaviour, address-0 handling, protocol error and mid-run reset.
module tb_regfile_wr_arbiter;
  logic clock__i;
  logic rst_n__i;
  int   tests_run;
  int   tests_failed;

  regfile_wr_arbiter_if bus_if ();

  regfile_wr_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clock__i (clock__i),
    .rst_n__i (rst_n__i),
    .bus      (bus_if.slave)
  );

  // clock / reset
  initial clock__i = 1'b0;
  always #5 clock__i = ~clock__i;

  task automatic step();
    @(posedge clock__i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus_if.WbValid__i = v;
    bus_if.WbAddr__i  = a;
    bus_if.WbData__i  = d;
  endtask

  task automatic drive_ll(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus_if.LlValid__i = v;
    bus_if.LlAddr__i  = a;
    bus_if.LlData__i  = d;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n__i     = 1'b0;
    drive_wb(1'b1, 5'd5, 32'h1234);
    drive_ll(1'b0, 5'd0, 32'h0);

    // reset state
    step();
    step();
    chk("rst_regwrite", 32'(bus_if.RegWrite__o), 32'd0);
    chk("rst_llready",  32'(bus_if.LlReady__o),  32'd1);
    chk("rst_pendmask", bus_if.PendMask__o,      32'd0);
    chk("rst_stall",    32'(bus_if.StallReq__o), 32'd0);
    chk("rst_protoerr", 32'(bus_if.ProtoErr__o), 32'd0);
    rst_n__i = 1'b1;
    drive_wb(1'b0, 5'd0, 32'h0);

    // 1: WB write with idle FIFO
    step();
    drive_wb(1'b1, 5'd5, 32'h1234);
    #1;
    chk("t1_regwrite", 32'(bus_if.RegWrite__o), 32'd1);
    chk("t1_addr",     32'(bus_if.AddrRd__o),   32'd5);
    chk("t1_data",     bus_if.DataRd__o,        32'h1234);
    chk("t1_llready",  32'(bus_if.LlReady__o),  32'd1);
    chk("t1_pendmask", bus_if.PendMask__o,      32'd0);

    // 2: LL push r9, drains into idle slot next cycle
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_ll(1'b1, 5'd9, 32'hAA);
    #1;
    chk("t2_no_bypass", 32'(bus_if.RegWrite__o), 32'd0);
    step();
    drive_ll(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_pend9",    bus_if.PendMask__o,      32'h0000_0200);
    chk("t2_regwrite", 32'(bus_if.RegWrite__o), 32'd1);
    chk("t2_addr",     32'(bus_if.AddrRd__o),   32'd9);
    chk("t2_data",     bus_if.DataRd__o,        32'hAA);
    step();
    chk("t2_pend_clr", bus_if.PendMask__o,      32'd0);
    chk("t2_idle",     32'(bus_if.RegWrite__o), 32'd0);

    // 3: starvation raises StallReq after MAX_WAIT lost cycles
    drive_wb(1'b1, 5'd7, 32'h77);
    drive_ll(1'b1, 5'd3, 32'h33);
    #1;
    chk("t3_wb_first", 32'(bus_if.AddrRd__o), 32'd7);
    step();
    drive_ll(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_no_stall", 32'(bus_if.StallReq__o), 32'd0);
      chk("t3_wb_wins",  32'(bus_if.AddrRd__o),   32'd7);
      step();
    end
    drive_wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_stall",    32'(bus_if.StallReq__o), 32'd1);
    chk("t3_regwrite", 32'(bus_if.RegWrite__o), 32'd1);
    chk("t3_addr",     32'(bus_if.AddrRd__o),   32'd3);
    chk("t3_data",     bus_if.DataRd__o,        32'h33);
    step();
    chk("t3_stall_fall", 32'(bus_if.StallReq__o), 32'd0);
    chk("t3_protoerr",   32'(bus_if.ProtoErr__o), 32'd0);
    chk("t3_idle",       32'(bus_if.RegWrite__o), 32'd0);

    // 4: fill FIFO, rejected push on full even with pop, in-order drain
    drive_wb(1'b1, 5'd8, 32'h88);
    drive_ll(1'b1, 5'd1, 32'h11);
    #1;
    chk("t4_ready0", 32'(bus_if.LlReady__o), 32'd1);
    step();
    drive_ll(1'b1, 5'd2, 32'h22);
    #1;
    chk("t4_ready1", 32'(bus_if.LlReady__o), 32'd1);
    chk("t4_pend1",  bus_if.PendMask__o,     32'h0000_0002);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_ll(1'b1, 5'd4, 32'h44);
    #1;
    chk("t4_full",      32'(bus_if.LlReady__o),  32'd0);
    chk("t4_pend12",    bus_if.PendMask__o,      32'h0000_0006);
    chk("t4_r1_write",  32'(bus_if.RegWrite__o), 32'd1);
    chk("t4_r1_addr",   32'(bus_if.AddrRd__o),   32'd1);
    chk("t4_r1_data",   bus_if.DataRd__o,        32'h11);
    step();
    drive_ll(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_pend2",     bus_if.PendMask__o,      32'h0000_0004);
    chk("t4_r2_write",  32'(bus_if.RegWrite__o), 32'd1);
    chk("t4_r2_addr",   32'(bus_if.AddrRd__o),   32'd2);
    chk("t4_r2_data",   bus_if.DataRd__o,        32'h22);
    chk("t4_ready_back", 32'(bus_if.LlReady__o), 32'd1);
    step();
    chk("t4_no_third",  32'(bus_if.RegWrite__o), 32'd0);
    chk("t4_pend_empty", bus_if.PendMask__o,     32'd0);

    // 5a: address 0 entry is consumed without a write
    drive_ll(1'b1, 5'd0, 32'hFF);
    step();
    drive_ll(1'b0, 5'd0, 32'h0);
    drive_wb(1'b0, 5'd12, 32'hC);
    #1;
    chk("t5_pend_bit0", bus_if.PendMask__o,      32'd0);
    chk("t5_addr0",     32'(bus_if.AddrRd__o),   32'd0);
    chk("t5_no_write",  32'(bus_if.RegWrite__o), 32'd0);
    step();
    chk("t5_popped",    32'(bus_if.AddrRd__o),   32'd12);
    chk("t5_idle",      32'(bus_if.RegWrite__o), 32'd0);

    // 5b: WB held during stall sets sticky ProtoErr
    drive_wb(1'b1, 5'd6, 32'h66);
    drive_ll(1'b1, 5'd0, 32'hFF);
    step();
    drive_ll(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_no_stall", 32'(bus_if.StallReq__o), 32'd0);
      step();
    end
    #1;
    chk("t5_stall",      32'(bus_if.StallReq__o), 32'd1);
    chk("t5_head_wins",  32'(bus_if.AddrRd__o),   32'd0);
    chk("t5_head_nowr",  32'(bus_if.RegWrite__o), 32'd0);
    chk("t5_perr_pre",   32'(bus_if.ProtoErr__o), 32'd0);
    step();
    chk("t5_perr_set",   32'(bus_if.ProtoErr__o), 32'd1);
    chk("t5_stall_fall", 32'(bus_if.StallReq__o), 32'd0);
    chk("t5_wb_back",    32'(bus_if.AddrRd__o),   32'd6);
    chk("t5_wb_write",   32'(bus_if.RegWrite__o), 32'd1);
    drive_wb(1'b0, 5'd0, 32'h0);
    step();
    step();
    chk("t5_perr_sticky", 32'(bus_if.ProtoErr__o), 32'd1);

    // 6: reset with two entries queued discards them
    drive_wb(1'b1, 5'd6, 32'h66);
    drive_ll(1'b1, 5'd10, 32'hA);
    step();
    drive_ll(1'b1, 5'd11, 32'hB);
    step();
    drive_ll(1'b0, 5'd0, 32'h0);
    #1;
    chk("t6_pend_two", bus_if.PendMask__o, 32'h0000_0C00);
    drive_wb(1'b0, 5'd6, 32'h66);
    rst_n__i = 1'b0;
    #1;
    chk("t6_rst_pend",     bus_if.PendMask__o,      32'd0);
    chk("t6_rst_stall",    32'(bus_if.StallReq__o), 32'd0);
    chk("t6_rst_regwrite", 32'(bus_if.RegWrite__o), 32'd0);
    chk("t6_rst_perr",     32'(bus_if.ProtoErr__o), 32'd0);
    chk("t6_rst_ready",    32'(bus_if.LlReady__o),  32'd1);
    step();
    rst_n__i = 1'b1;
    #1;
    chk("t6_post_write0", 32'(bus_if.RegWrite__o), 32'd0);
    chk("t6_post_pend",   bus_if.PendMask__o,      32'd0);
    step();
    chk("t6_post_write1", 32'(bus_if.RegWrite__o), 32'd0);
    chk("t6_post_addr",   32'(bus_if.AddrRd__o),   32'd6);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
